// File: rtl/gt_usplus_qpll_reset_sequencer.sv
// QPLL0 reset sequencer for one or two GTYE4_COMMON quads: pulses reset, waits for
// lock, debounces it, retries on timeout and re-initialises on loss of lock.
module gt_usplus_qpll_reset_sequencer #(
    parameter int unsigned N_COMMON            = 2,
    parameter int unsigned RESET_HOLD_CYCLES   = 256,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned AUTO_START          = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [N_COMMON-1:0]              qpll0lock,
    output logic [N_COMMON-1:0]              qpll0reset,
    output logic [N_COMMON-1:0]              qpll1reset,
    output logic                             all_locked,
    output logic                             fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
    output logic [7:0]                       lol_count,
    output logic [2:0]                       state
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int unsigned MAX_HT  = (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RESET_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_HT > LOCK_STABLE_CYCLES) ? MAX_HT : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_WAIT   = 3'd2,
        S_STABLE = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 cnt_clr;
    logic [RETRY_W-1:0]   retry_d;
    logic [7:0]           lol_d;
    logic [N_COMMON-1:0]  lock_meta;
    logic [N_COMMON-1:0]  lock_sync;
    logic                 lock_all;

    // Two-flop synchroniser per COMMON; lock is only trusted when every quad reports it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= '0;
            lock_sync <= '0;
        end else begin
            lock_meta <= qpll0lock;
            lock_sync <= lock_meta;
        end
    end

    assign lock_all = &lock_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; start overrides every other transition
    always_comb begin
        state_d = state_q;
        retry_d = retry_count;
        lol_d   = lol_count;
        cnt_clr = 1'b0;
        if (start) begin
            state_d = S_RESET;
            retry_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (AUTO_START != 0) begin
                        state_d = S_RESET;
                    end
                end
                S_RESET: begin
                    if (cnt_q == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lock_all) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        if (retry_count < RETRY_W'(MAX_RETRIES)) begin
                            retry_d = retry_count + RETRY_W'(1);
                            state_d = S_RESET;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_all) begin
                        state_d = S_WAIT;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d = S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (!lock_all) begin
                        if (lol_count != 8'hFF) begin
                            lol_d = lol_count + 8'd1;
                        end
                        retry_d = '0;
                        state_d = S_RESET;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        cnt_clr = start || (state_d != state_q);
    end

    // Shared phase counter: restarts on every state entry, runs only in timed states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (state_q inside {S_RESET, S_WAIT, S_STABLE}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Outputs decoded from the next state so they move on the same edge as the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qpll0reset  <= '1;
            qpll1reset  <= '1;
            all_locked  <= 1'b0;
            fail        <= 1'b0;
            retry_count <= '0;
            lol_count   <= '0;
        end else begin
            qpll0reset  <= {N_COMMON{state_d inside {S_IDLE, S_RESET, S_FAIL}}};
            qpll1reset  <= '1;
            all_locked  <= (state_d == S_LOCKED);
            fail        <= (state_d == S_FAIL);
            retry_count <= retry_d;
            lol_count   <= lol_d;
        end
    end

    assign state = state_q;

endmodule
